// File: rtl/sram_like_arbiter.sv
// Two-client (inst/data) sram-like arbiter onto one memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to alternate priority on conflicts; default is data-over-inst.
module sram_like_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic                  inst_wr,
  input  logic [1:0]            inst_size,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic [31:0]           inst_wdata,
  output logic [31:0]           inst_rdata,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic [31:0]           data_rdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [1:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e state_q;
  logic   owner_q;   // 0 = inst, 1 = data
  logic   any_req, win, sel, addr_hs, data_hs;

  assign any_req = inst_req | data_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;
  assign win = data_req & (~inst_req | ~last_q);
`else
  assign win = data_req;
`endif

  // Arbitration only happens in IDLE; afterwards the owner holds the port.
  assign sel = (state_q == IDLE) ? win : owner_q;

  always_comb begin
    mem_req   = rst & ((state_q == ADDR) | ((state_q == IDLE) & any_req));
    mem_wr    = sel ? data_wr    : inst_wr;
    mem_size  = sel ? data_size  : inst_size;
    mem_addr  = sel ? data_addr  : inst_addr;
    mem_wdata = sel ? data_wdata : inst_wdata;
  end

  assign addr_hs      = mem_req & mem_addr_ok;
  assign data_hs      = rst & (state_q == DATA) & mem_data_ok;
  assign inst_addr_ok = addr_hs & ~sel;
  assign data_addr_ok = addr_hs &  sel;
  assign inst_data_ok = data_hs & ~owner_q;
  assign data_data_ok = data_hs &  owner_q;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign busy         = rst & (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          owner_q <= win;
`ifdef ARB_ROUND_ROBIN_EN
          last_q  <= win;
`endif
          state_q <= mem_addr_ok ? DATA : ADDR;
        end
        ADDR: if (mem_addr_ok) state_q <= DATA;
        DATA: if (mem_data_ok) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
